min_max_amplitude: RTL and testbench
====================================

MIN_MAX_AMPLITUDE -- requirements
Module: min_max_amplitude

Interface
REQ-001 Parameter DATA_W, default 16: sample and min/max width, two's-complement signed.
REQ-002 Parameter CNT_W, default 32: width of the sample counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 sample_in  input  DATA_W signed  audio sample.
REQ-006 sample_valid  input  1  high = sample_in is valid this cycle; no back-pressure.
REQ-007 min_out  output  DATA_W signed  most negative sample accepted since reset.
REQ-008 max_out  output  DATA_W signed  most positive sample accepted since reset.
REQ-009 have_data  output  1  high once at least one sample has been accepted.
REQ-010 span_out  output  DATA_W+1 unsigned  max_out minus min_out (peak-to-peak).
REQ-011 count_out  output  CNT_W unsigned  number of accepted samples, saturating.

Function
REQ-012 A sample is accepted on any rising edge where rst=0 and sample_valid=1; one sample per cycle, back-to-back allowed.
REQ-013 All outputs are registered; an accepted sample is reflected on the outputs in the cycle after its accepting edge (latency 1).
REQ-014 First accepted sample after reset loads both min_out and max_out with that sample and sets have_data=1.
REQ-015 Later samples: min_out <= sample_in if sample_in < min_out (signed compare); max_out <= sample_in if sample_in > max_out; otherwise hold.
REQ-016 A sample equal to the current min_out or max_out leaves that output unchanged.
REQ-017 A single sample can update both extremes only as the first sample; afterwards at most one extreme changes per sample.
REQ-018 sample_valid=0: all outputs hold.
REQ-019 span_out = max_out - min_out computed at DATA_W+1 bits, so no overflow; span_out is registered together with min_out/max_out and is consistent with them in the same cycle.
REQ-020 count_out increments by 1 per accepted sample and saturates at 2^CNT_W-1.
REQ-021 Extremes -32768 and +32767 (DATA_W=16) are legal and are tracked exactly.

Reset
REQ-022 When rst=1 at a rising edge: min_out=0, max_out=0, span_out=0, count_out=0, have_data=0; sample_valid is ignored during that edge.
REQ-023 Reset asserted mid-stream discards all history; the first accepted sample after reset reinitialises per REQ-014.
REQ-024 No asynchronous reset paths; outputs are undefined only before the first clock edge with rst=1.

Structure
REQ-025 Shared package min_max_pkg holds DATA_W and CNT_W defaults and the reset constants for the extremes and the counter.
REQ-026 One sub-module, minmax_cmp_update: combinational signed compare of sample against current min/max producing the next min and max plus an update flag; instantiated once.
REQ-027 Top level holds the registers, have_data, the counter and the span subtraction.

Verification
REQ-028 Reset, then samples 100, -200, 50, 300, -10 back-to-back -> after last: min_out=-200, max_out=300, span_out=500, count_out=5, have_data=1.
REQ-029 Single sample -7 after reset -> min_out=max_out=-7, span_out=0, count_out=1.
REQ-030 Samples -32768 then 32767 -> min_out=-32768, max_out=32767, span_out=65535.
REQ-031 Samples 10, then sample_valid=0 with sample_in=999 for 3 cycles -> outputs stay min=max=10, count_out=1.
REQ-032 Samples 5, 500, then rst pulse, then 20 -> after reset all outputs 0 and have_data=0; after 20: min=max=20, count_out=1.
REQ-033 Repeated equal samples 42,42,42 -> min=max=42, count_out=3; latency check: the outputs change exactly one cycle after each accepting edge.

Source files
------------

// File: rtl/min_max_amplitude_pkg.sv
// Shared defaults and reset values for the min/max amplitude tracker.
package min_max_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int CNT_W_DEF  = 32;

    localparam int EXT_RST_VAL = 0;
    localparam int CNT_RST_VAL = 0;

endpackage

// File: rtl/min_max_amplitude_cmp_update.sv
// Combinational signed compare of a sample against the running extremes.
module minmax_cmp_update
    import min_max_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic signed [DATA_W-1:0] sample,
    input  logic signed [DATA_W-1:0] cur_min,
    input  logic signed [DATA_W-1:0] cur_max,
    input  logic                     first,
    output logic signed [DATA_W-1:0] next_min,
    output logic signed [DATA_W-1:0] next_max,
    output logic                     update
);

    logic lt_min;
    logic gt_max;

    assign lt_min = sample < cur_min;
    assign gt_max = sample > cur_max;

    // Once primed min <= max, so lt_min and gt_max cannot both be set.
    always_comb begin
        next_min = cur_min;
        next_max = cur_max;
        update   = 1'b0;
        unique case (1'b1)
            first: begin
                next_min = sample;
                next_max = sample;
                update   = 1'b1;
            end
            (!first && lt_min): begin
                next_min = sample;
                update   = 1'b1;
            end
            (!first && gt_max): begin
                next_max = sample;
                update   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/min_max_amplitude.sv
// Tracks min, max, peak-to-peak span and a saturating sample count.
module min_max_amplitude
    import min_max_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] sample_in,
    input  logic                     sample_valid,
    output logic signed [DATA_W-1:0] min_out,
    output logic signed [DATA_W-1:0] max_out,
    output logic                     have_data,
    output logic        [DATA_W:0]   span_out,
    output logic        [CNT_W-1:0]  count_out
);

    logic signed [DATA_W-1:0] min_q, min_d;
    logic signed [DATA_W-1:0] max_q, max_d;
    logic        [DATA_W:0]   span_q, span_d;
    logic        [CNT_W-1:0]  cnt_q, cnt_d;
    logic                     have_q, have_d;

    logic signed [DATA_W-1:0] nxt_min;
    logic signed [DATA_W-1:0] nxt_max;
    logic                     upd;

    minmax_cmp_update #(
        .DATA_W (DATA_W)
    ) u_cmp (
        .sample   (sample_in),
        .cur_min  (min_q),
        .cur_max  (max_q),
        .first    (!have_q),
        .next_min (nxt_min),
        .next_max (nxt_max),
        .update   (upd)
    );

    always_comb begin
        min_d  = min_q;
        max_d  = max_q;
        span_d = span_q;
        cnt_d  = cnt_q;
        have_d = have_q;
        if (sample_valid) begin
            have_d = 1'b1;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (upd) begin
                min_d  = nxt_min;
                max_d  = nxt_max;
                // Sign-extend both so the difference never overflows.
                span_d = {nxt_max[DATA_W-1], nxt_max}
                       - {nxt_min[DATA_W-1], nxt_min};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            min_q  <= DATA_W'(EXT_RST_VAL);
            max_q  <= DATA_W'(EXT_RST_VAL);
            span_q <= '0;
            cnt_q  <= CNT_W'(CNT_RST_VAL);
            have_q <= 1'b0;
        end else begin
            min_q  <= min_d;
            max_q  <= max_d;
            span_q <= span_d;
            cnt_q  <= cnt_d;
            have_q <= have_d;
        end
    end

    assign min_out   = min_q;
    assign max_out   = max_q;
    assign span_out  = span_q;
    assign count_out = cnt_q;
    assign have_data = have_q;

endmodule

// File: tb/tb_min_max_amplitude.sv
// Vector table, latency check and randomized run against a sample-history model.
module tb_min_max_amplitude;

    localparam int DW = 16;
    localparam int SAT_W = 3;
    localparam longint SAT_MAX = (1 << SAT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic signed [DW-1:0] sample_in = '0;
    logic sample_valid = 1'b0;

    logic signed [DW-1:0] min_out, max_out;
    logic have_data;
    logic [DW:0] span_out;
    logic [31:0] count_out;

    logic signed [DW-1:0] s_min, s_max;
    logic s_have;
    logic [DW:0] s_span;
    logic [SAT_W-1:0] s_count;

    int tests = 0;
    int fails = 0;

    // History of samples accepted since the last reset.
    int hist[$];

    always #5 clk = ~clk;

    min_max_amplitude dut (
        .clk (clk), .rst (rst),
        .sample_in (sample_in), .sample_valid (sample_valid),
        .min_out (min_out), .max_out (max_out),
        .have_data (have_data), .span_out (span_out),
        .count_out (count_out)
    );

    min_max_amplitude #(.DATA_W(DW), .CNT_W(SAT_W)) dut_sat (
        .clk (clk), .rst (rst),
        .sample_in (sample_in), .sample_valid (sample_valid),
        .min_out (s_min), .max_out (s_max),
        .have_data (s_have), .span_out (s_span),
        .count_out (s_count)
    );

    typedef struct {
        bit     r;
        bit     v;
        int     d;
        longint e_min;
        longint e_max;
        longint e_span;
        longint e_cnt;
        bit     e_have;
    } vec_t;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint m_min();
        longint m = hist[0];
        foreach (hist[i]) if (hist[i] < m) m = hist[i];
        return m;
    endfunction

    function automatic longint m_max();
        longint m = hist[0];
        foreach (hist[i]) if (hist[i] > m) m = hist[i];
        return m;
    endfunction

    // Drive at negedge, let one rising edge happen, return at next negedge.
    task automatic apply(input bit r, input bit v, input int d);
        rst = r;
        sample_valid = v;
        sample_in = DW'(d);
        @(posedge clk);
        if (r) hist.delete();
        else if (v) hist.push_back(d);
        @(negedge clk);
    endtask

    task automatic chk_model(input string tag);
        longint mn, mx, n;
        n = hist.size();
        mn = (n == 0) ? 0 : m_min();
        mx = (n == 0) ? 0 : m_max();
        chk({tag, " min"}, longint'(min_out), mn);
        chk({tag, " max"}, longint'(max_out), mx);
        chk({tag, " span"}, longint'(span_out), mx - mn);
        chk({tag, " count"}, longint'(count_out), n);
        chk({tag, " have"}, longint'(have_data), longint'(n != 0));
        chk({tag, " sat_count"}, longint'(s_count), (n > SAT_MAX) ? SAT_MAX : n);
        chk({tag, " sat_span"}, longint'(s_span), mx - mn);
    endtask

    vec_t tbl[$];

    initial begin
        tbl = '{
            '{1, 0, 0,      0,      0,     0, 0, 0},
            '{0, 1, 100,    100,    100,   0, 1, 1},
            '{0, 1, -200,   -200,   100, 300, 2, 1},
            '{0, 1, 50,     -200,   100, 300, 3, 1},
            '{0, 1, 300,    -200,   300, 500, 4, 1},
            '{0, 1, -10,    -200,   300, 500, 5, 1},
            '{1, 1, 77,     0,      0,     0, 0, 0},
            '{0, 1, -7,     -7,     -7,    0, 1, 1},
            '{1, 0, 0,      0,      0,     0, 0, 0},
            '{0, 1, -32768, -32768, -32768, 0, 1, 1},
            '{0, 1, 32767,  -32768, 32767, 65535, 2, 1},
            '{1, 0, 0,      0,      0,     0, 0, 0},
            '{0, 1, 10,     10,     10,    0, 1, 1},
            '{0, 0, 999,    10,     10,    0, 1, 1},
            '{0, 0, 999,    10,     10,    0, 1, 1},
            '{0, 0, 999,    10,     10,    0, 1, 1},
            '{1, 0, 0,      0,      0,     0, 0, 0},
            '{0, 1, 5,      5,      5,     0, 1, 1},
            '{0, 1, 500,    5,      500, 495, 2, 1},
            '{1, 0, 0,      0,      0,     0, 0, 0},
            '{0, 1, 20,     20,     20,    0, 1, 1},
            '{1, 0, 0,      0,      0,     0, 0, 0},
            '{0, 1, 42,     42,     42,    0, 1, 1},
            '{0, 1, 42,     42,     42,    0, 2, 1},
            '{0, 1, 42,     42,     42,    0, 3, 1}
        };

        @(negedge clk);
        foreach (tbl[i]) begin
            string t;
            t = $sformatf("vec%0d", i);
            apply(tbl[i].r, tbl[i].v, tbl[i].d);
            chk({t, " min"}, longint'(min_out), tbl[i].e_min);
            chk({t, " max"}, longint'(max_out), tbl[i].e_max);
            chk({t, " span"}, longint'(span_out), tbl[i].e_span);
            chk({t, " count"}, longint'(count_out), tbl[i].e_cnt);
            chk({t, " have"}, longint'(have_data), longint'(tbl[i].e_have));
        end

        // Latency: new max must not appear before the accepting edge.
        rst = 1'b0;
        sample_valid = 1'b1;
        sample_in = 16'sd77;
        #1;
        chk("lat pre max", longint'(max_out), 42);
        chk("lat pre count", longint'(count_out), 3);
        @(posedge clk);
        hist.push_back(77);
        #1;
        chk("lat post max", longint'(max_out), 77);
        chk("lat post min", longint'(min_out), 42);
        chk("lat post span", longint'(span_out), 35);
        chk("lat post count", longint'(count_out), 4);
        sample_valid = 1'b0;
        @(negedge clk);
        chk_model("lat hold");

        // Saturation of the narrow counter instance.
        for (int i = 0; i < 6; i++) apply(0, 1, i - 3);
        chk_model("sat");

        for (int i = 0; i < 600; i++) begin
            bit r, v;
            int d;
            r = ($urandom_range(0, 59) == 0);
            v = ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 9))
                0: d = -32768;
                1: d = 32767;
                2: d = $urandom_range(0, 20) - 10;
                default: d = int'($urandom_range(0, 65535)) - 32768;
            endcase
            apply(r, v, d);
            chk_model($sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
